// File: rtl/game_logic_param.sv
// Word-guessing game: latch a word, accept ASCII letter guesses, reveal matching positions.
// A guess taken at edge N resolves after edge N+WORD_LEN+1; guesses are only taken while game_rdy is high.
module game_logic_param #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  toggle_state,
    input  logic [8*WORD_LEN-1:0] setWord,
    input  logic [7:0]            guess,
    input  logic                  guess_valid,
    output logic                  game_rdy,
    output logic                  busy,
    output logic [3:0]            correct,
    output logic [2:0]            incorrect,
    output logic [WORD_LEN-1:0]   indexCorrect,
    output logic                  green,
    output logic                  mistake,
    output logic                  repeat_guess,
    output logic                  invalid,
    output logic                  gameEnd,
    output logic                  win
);
    localparam int PW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {IDLE, PLAY, CHECK, WIN, LOSE} state_t;

    state_t                state, state_nxt;
    logic                  tog_prev, tog_edge;
    logic [8*WORD_LEN-1:0] word;
    logic [7:0]            guess_q, guess_off;
    logic [25:0]           used, guess_bit;
    logic [WORD_LEN-1:0]   hit_mask, hits_all, new_bits;
    logic [PW-1:0]         pos;
    logic                  pend, guess_alpha, last_pos, any_hit;
    logic [3:0]            new_cnt, correct_sum;
    logic [2:0]            incorrect_inc;

    assign tog_edge      = toggle_state & ~tog_prev;
    assign guess_alpha   = (guess >= 8'h41) && (guess <= 8'h5A);
    assign guess_off     = guess - 8'h41;
    assign guess_bit     = 26'd1 << guess_off;
    assign last_pos      = (int'(pos) == WORD_LEN - 1);
    assign any_hit       = |hits_all;
    assign correct_sum   = correct + new_cnt;
    assign incorrect_inc = incorrect + 3'd1;

    // Only positions not yet revealed add to the score, so correct can never pass WORD_LEN.
    always_comb begin
        hits_all = hit_mask;
        if (word[8*(WORD_LEN-1-int'(pos)) +: 8] == guess_q)
            hits_all[WORD_LEN-1-int'(pos)] = 1'b1;
        new_bits = hits_all & ~indexCorrect;
        new_cnt  = '0;
        for (int i = 0; i < WORD_LEN; i++)
            new_cnt = new_cnt + 4'(new_bits[i]);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tog_edge) state_nxt = PLAY;
            PLAY:  if (pend) state_nxt = CHECK;
            CHECK: begin
                if (last_pos) begin
                    if (any_hit && correct_sum == 4'(WORD_LEN))
                        state_nxt = WIN;
                    else if (!any_hit && incorrect_inc == 3'(MAX_MISTAKES))
                        state_nxt = LOSE;
                    else
                        state_nxt = PLAY;
                end
            end
            WIN, LOSE: if (tog_edge) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        game_rdy = (state == PLAY) && !pend;
        busy     = (state == CHECK);
        gameEnd  = (state == WIN) || (state == LOSE);
        win      = (state == WIN);
    end

    // pend marks the one PLAY cycle between accepting a fresh letter and starting the scan.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tog_prev     <= 1'b1;
            word         <= '0;
            guess_q      <= '0;
            used         <= '0;
            hit_mask     <= '0;
            pos          <= '0;
            pend         <= 1'b0;
            correct      <= '0;
            incorrect    <= '0;
            indexCorrect <= '0;
            green        <= 1'b0;
            mistake      <= 1'b0;
            repeat_guess <= 1'b0;
            invalid      <= 1'b0;
        end else begin
            tog_prev     <= toggle_state;
            green        <= 1'b0;
            mistake      <= 1'b0;
            repeat_guess <= 1'b0;
            invalid      <= 1'b0;
            case (state)
                IDLE: begin
                    if (tog_edge) begin
                        word         <= setWord;
                        correct      <= '0;
                        incorrect    <= '0;
                        indexCorrect <= '0;
                        used         <= '0;
                        pend         <= 1'b0;
                    end
                end
                PLAY: begin
                    if (pend) begin
                        pend     <= 1'b0;
                        pos      <= '0;
                        hit_mask <= '0;
                    end else if (guess_valid) begin
                        guess_q <= guess;
                        if (!guess_alpha)
                            invalid <= 1'b1;
                        else if (|(used & guess_bit))
                            repeat_guess <= 1'b1;
                        else begin
                            used <= used | guess_bit;
                            pend <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (last_pos) begin
                        hit_mask <= '0;
                        pos      <= '0;
                        if (any_hit) begin
                            indexCorrect <= indexCorrect | hits_all;
                            correct      <= correct_sum;
                            green        <= 1'b1;
                        end else begin
                            if (incorrect < 3'(MAX_MISTAKES))
                                incorrect <= incorrect_inc;
                            mistake <= 1'b1;
                        end
                    end else begin
                        hit_mask <= hits_all;
                        pos      <= PW'(pos + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_logic_param.sv
// Bench for game_logic_param: directed scenarios plus random games scored by a letter-level model.
module tb_game_logic_param;
    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic        nRst, toggle_state, guess_valid;
    logic [39:0] setWord;
    logic [7:0]  guess;
    logic        game_rdy, busy, green, mistake, repeat_guess, invalid, gameEnd, win;
    logic [3:0]  correct;
    logic [2:0]  incorrect;
    logic [4:0]  indexCorrect;

    logic        b_toggle, b_guess_valid;
    logic [23:0] b_setWord;
    logic [7:0]  b_guess;
    logic        b_game_rdy, b_busy, b_green, b_mistake, b_repeat, b_invalid, b_gameEnd, b_win;
    logic [3:0]  b_correct;
    logic [2:0]  b_incorrect;
    logic [2:0]  b_indexCorrect;

    game_logic_param #(.WORD_LEN(5), .MAX_MISTAKES(6)) dut (
        .clk(tb_clk), .nRst(nRst), .toggle_state(toggle_state), .setWord(setWord),
        .guess(guess), .guess_valid(guess_valid), .game_rdy(game_rdy), .busy(busy),
        .correct(correct), .incorrect(incorrect), .indexCorrect(indexCorrect),
        .green(green), .mistake(mistake), .repeat_guess(repeat_guess), .invalid(invalid),
        .gameEnd(gameEnd), .win(win)
    );

    game_logic_param #(.WORD_LEN(3), .MAX_MISTAKES(2)) dut_b (
        .clk(tb_clk), .nRst(nRst), .toggle_state(b_toggle), .setWord(b_setWord),
        .guess(b_guess), .guess_valid(b_guess_valid), .game_rdy(b_game_rdy), .busy(b_busy),
        .correct(b_correct), .incorrect(b_incorrect), .indexCorrect(b_indexCorrect),
        .green(b_green), .mistake(b_mistake), .repeat_guess(b_repeat), .invalid(b_invalid),
        .gameEnd(b_gameEnd), .win(b_win)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Letter-level model of the 5-letter game.
    logic [7:0] m_word [5];
    bit         m_seen [26];
    bit         m_rev  [5];
    int         m_correct, m_incorrect;

    function automatic logic [4:0] rev_mask();
        logic [4:0] m;
        for (int i = 0; i < 5; i++) m[4-i] = m_rev[i];
        return m;
    endfunction

    function automatic bit m_over();
        return (m_correct == 5) || (m_incorrect == 6);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    task automatic a_start(input logic [39:0] w);
        setWord      = w;
        toggle_state = 1'b1;
        tick();
        toggle_state = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_word[i] = w[8*(4-i) +: 8];
            m_rev[i]  = 1'b0;
        end
        for (int i = 0; i < 26; i++) m_seen[i] = 1'b0;
        m_correct   = 0;
        m_incorrect = 0;
        check("start_rdy", game_rdy, 1);
        check("start_counters", {correct, incorrect, indexCorrect, gameEnd}, 0);
    endtask

    task automatic a_guess(input logic [7:0] g, input bit hold, input bit tog);
        int kind;
        int hits;
        hits = 0;
        if (g < 8'h41 || g > 8'h5A) kind = 0;
        else if (m_seen[g - 8'h41]) kind = 1;
        else begin
            kind = 2;
            m_seen[g - 8'h41] = 1'b1;
            for (int i = 0; i < 5; i++)
                if (m_word[i] == g) begin
                    hits++;
                    m_rev[i] = 1'b1;
                end
            if (hits > 0) m_correct += hits;
            else          m_incorrect++;
        end
        guess        = g;
        guess_valid  = 1'b1;
        toggle_state = tog;
        tick();
        toggle_state = 1'b0;
        if (!hold || kind < 2) guess_valid = 1'b0;
        if (kind < 2) begin
            check("reject_pulse", {green, mistake, repeat_guess, invalid}, {2'b00, kind == 1, kind == 0});
            check("reject_counters", {correct, incorrect}, {4'(m_correct), 3'(m_incorrect)});
            check("reject_rdy", game_rdy, 1);
        end else begin
            check("accept_busy", busy, 0);
            for (int c = 0; c < 5; c++) begin
                tick();
                check("busy", busy, 1);
            end
            tick();
            guess_valid = 1'b0;
            check("busy_done", busy, 0);
            check("result_pulse", {green, mistake, repeat_guess, invalid}, {hits > 0, hits == 0, 2'b00});
            check("correct", correct, m_correct);
            check("incorrect", incorrect, m_incorrect);
            check("indexCorrect", indexCorrect, rev_mask());
            check("end_flags", {gameEnd, win, game_rdy}, {m_over(), m_correct == 5, !m_over()});
        end
        tick();
        check("pulse_clear", {green, mistake, repeat_guess, invalid}, 0);
    endtask

    task automatic a_exit();
        toggle_state = 1'b1;
        tick();
        toggle_state = 1'b0;
        check("exit_flags", {gameEnd, win, game_rdy}, 0);
        check("exit_hold", {correct, incorrect, indexCorrect}, {4'(m_correct), 3'(m_incorrect), rev_mask()});
        tick();
    endtask

    task automatic b_do_guess(input logic [7:0] g);
        b_guess       = g;
        b_guess_valid = 1'b1;
        tick();
        b_guess_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        nRst = 1'b0; toggle_state = 1'b1; guess_valid = 1'b0; guess = '0; setWord = '0;
        b_toggle = 1'b0; b_guess_valid = 1'b0; b_guess = '0; b_setWord = '0;
        @(negedge tb_clk);
        check("reset_outputs", {game_rdy, busy, correct, incorrect, indexCorrect,
                                green, mistake, repeat_guess, invalid, gameEnd, win}, 0);
        nRst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("held_toggle_no_start", game_rdy, 0);
        end
        toggle_state = 1'b0;
        tick();

        // Six misses on APPLE.
        a_start("APPLE");
        a_guess("C", 0, 0); a_guess("J", 0, 0); a_guess("Q", 0, 0);
        a_guess("R", 0, 0); a_guess("K", 0, 0); a_guess("M", 0, 0);
        a_exit();

        // Straight win on APPLE.
        a_start("APPLE");
        a_guess("A", 0, 0); a_guess("P", 0, 0); a_guess("L", 0, 0); a_guess("E", 0, 0);
        a_exit();

        // Repeats, invalid letter, word changed after latch, toggle ignored in PLAY.
        a_start("APPLE");
        setWord = "ZZZZZ";
        a_guess("P", 0, 0); a_guess("P", 0, 0); a_guess("Z", 0, 0);
        a_guess("Z", 0, 0); a_guess(8'h35, 0, 0);
        toggle_state = 1'b1;
        tick();
        toggle_state = 1'b0;
        check("toggle_in_play", {game_rdy, gameEnd}, 2'b10);
        a_guess("A", 0, 1); a_guess("L", 0, 0); a_guess("E", 0, 0);
        a_exit();

        // MOORE: guess_valid held during busy, then reset in CHECK cycle 3.
        a_start("MOORE");
        a_guess("M", 1, 0);
        guess = "O";
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("midcheck_busy", busy, 1);
        nRst = 1'b0;
        #1;
        check("midcheck_reset", {game_rdy, busy, correct, incorrect, indexCorrect,
                                 green, mistake, repeat_guess, invalid, gameEnd, win}, 0);
        @(negedge tb_clk);
        nRst = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("post_reset_idle", {game_rdy, busy, correct, incorrect, indexCorrect,
                                      green, mistake, repeat_guess, invalid, gameEnd, win}, 0);
        end

        // Random games.
        for (int gi = 0; gi < 3; gi++) begin
            logic [39:0] w;
            logic [7:0]  g;
            for (int i = 0; i < 5; i++) w[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 7));
            a_start(w);
            for (int k = 0; k < 25 && !m_over(); k++) begin
                if ($urandom_range(0, 9) == 0) g = 8'($urandom_range(0, 255));
                else                           g = 8'h41 + 8'($urandom_range(0, 11));
                a_guess(g, 1'($urandom_range(0, 1)), 0);
            end
            for (int c = 0; c < 26 && !m_over(); c++) a_guess(8'h41 + 8'(c), 0, 0);
            a_exit();
        end

        // Small instance: CAT, two misses lose.
        b_setWord = "CAT";
        b_toggle  = 1'b1;
        tick();
        b_toggle  = 1'b0;
        check("b_start_rdy", b_game_rdy, 1);
        b_do_guess("X");
        check("b_first_miss", {b_mistake, b_incorrect, b_gameEnd, b_game_rdy}, {1'b1, 3'd1, 1'b0, 1'b1});
        b_do_guess("Y");
        check("b_lose", {b_mistake, b_incorrect, b_gameEnd, b_win}, {1'b1, 3'd2, 1'b1, 1'b0});
        b_toggle = 1'b1;
        tick();
        b_toggle = 1'b0;
        check("b_exit_idle", {b_gameEnd, b_game_rdy, b_incorrect, b_correct}, {1'b0, 1'b0, 3'd2, 4'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/game_logic_param.md
GAME_LOGIC_PARAM -- requirements
Module: game_logic_param

Interface
REQ-001 SHALL have parameter WORD_LEN, 5, letters per word (legal 1..8).
REQ-002 SHALL have parameter MAX_MISTAKES, 6, wrong guesses that end the game (legal 1..7).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock
- nRst  in  1  asynchronous active-low reset
- toggle_state  in  1  host button; rising edge starts or exits a game
- setWord  in  8*WORD_LEN  ASCII word; first letter in the MS byte
- guess  in  8  ASCII guess letter
- guess_valid  in  1  guess offered this cycle
- game_rdy  out  1  high in PLAY; a guess may be accepted
- busy  out  1  high in CHECK
- correct  out  4  count of revealed positions
- incorrect  out  3  count of mistakes
- indexCorrect  out  WORD_LEN  revealed-position mask; bit WORD_LEN-1 is the first letter
- green / mistake / repeat_guess / invalid  out  1 each  one-cycle result pulses
- gameEnd  out  1  high in WIN or LOSE
- win  out  1  high in WIN only

Function
REQ-004 SHALL implement the states IDLE, PLAY, CHECK, WIN and LOSE.
REQ-005 SHALL detect a toggle_state rising edge against a previous-value register that resets to 1, so a level held high through reset does not start a game.
REQ-006 On a toggle_state edge in IDLE, SHALL:
- latch setWord;
- clear correct, incorrect, indexCorrect and the 26-bit used-letter bitmap;
- go to PLAY.
REQ-007 In PLAY, SHALL accept a guess when guess_valid=1 and SHALL latch it on that edge.
REQ-008 SHALL ignore guess_valid in every state other than PLAY.
REQ-009 A guess outside 0x41..0x5A SHALL:
- pulse invalid on the next cycle;
- change nothing else;
- stay in PLAY.
REQ-010 A guess whose used-letter bit is already set SHALL:
- pulse repeat_guess on the next cycle;
- leave the counters unchanged;
- stay in PLAY.
REQ-011 Any other guess SHALL set its used-letter bit and go to CHECK.
REQ-012 In CHECK, SHALL compare one position per cycle, index 0 (MS byte) first, for exactly WORD_LEN cycles, recording hits in a temporary mask.
REQ-013 On the edge that leaves CHECK, SHALL resolve the guess as follows:
- Any hits: OR the hits into indexCorrect, add the number of hits to correct, and pulse green.
- No hits: increment incorrect and pulse mistake.
REQ-014 A guess accepted at edge N SHALL produce counter and pulse updates visible after edge N+WORD_LEN+1.
REQ-015 Each result pulse SHALL be high for exactly one cycle.
REQ-016 When leaving CHECK, SHALL transition as follows:
- to WIN if correct equals WORD_LEN;
- else to LOSE if incorrect equals MAX_MISTAKES;
- else to PLAY.
REQ-017 On a toggle_state edge in WIN or LOSE, SHALL go to IDLE, with counters and indexCorrect holding their values until the next game start.
REQ-018 SHALL ignore toggle_state edges in PLAY and CHECK.
REQ-019 When guess_valid and a toggle_state edge occur in the same PLAY cycle, SHALL accept the guess and drop the toggle.
REQ-020 Counters SHALL NOT exceed WORD_LEN or MAX_MISTAKES.
REQ-021 A change on setWord after it is latched SHALL have no effect until the next game start.

Reset
REQ-022 While nRst=0, SHALL asynchronously force:
- state to IDLE;
- all outputs to 0;
- the bitmap and temporary mask to 0;
- the toggle previous-value register to 1.
REQ-023 Reset asserted mid-CHECK SHALL abort the guess with no pulse or counter update.

Verification
REQ-024 toggle_state held at 1 through reset, then kept high for 3 cycles -> game_rdy stays 0; a later 0->1 edge -> game_rdy=1.
REQ-025 Word APPLE; guesses C, J, Q, R, K, M -> incorrect steps 1..6 with six mistake pulses, then gameEnd=1, win=0, correct=0, indexCorrect=00000.
REQ-026 Word APPLE; guesses A, P, L, E -> correct 1, 3, 4, 5 and indexCorrect 10000, 11100, 11110, 11111, then win=1, gameEnd=1, incorrect=0.
REQ-027 Word APPLE; guesses P, P, Z, Z, 0x35 -> the pulse sequence is:
- green, then repeat_guess, then mistake, then repeat_guess, then invalid;
- final correct=2 and incorrect=1.
REQ-028 Word MOORE; guess M accepted at edge N -> busy high for 5 cycles; guess_valid=1 during busy is ignored; correct=1 after edge N+6; reset at CHECK cycle 3 -> IDLE with all outputs 0.
REQ-029 Instance with WORD_LEN=3, MAX_MISTAKES=2, word CAT; guesses X, Y -> LOSE after the second mistake; a toggle edge in LOSE -> IDLE.
